// File: rtl/alu_lockstep_pkg.sv
// Shared op-select encoding for the lockstep ALU lanes and checker.
package alu_lockstep_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_AND = 2'b10;
    localparam op_t OP_XOR = 2'b11;

endpackage

// File: rtl/alu_lane.sv
// One combinational ALU lane: ADD/SUB with carry/borrow, AND/XOR with carry 0.
module alu_lane
    import alu_lockstep_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              sel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] ext;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        case (sel)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            OP_SUB: begin
                // The extra bit of a wrapped subtraction is exactly the unsigned borrow.
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            OP_AND:  result = a & b;
            default: result = a ^ b;
        endcase
    end

endmodule

// File: rtl/alu_lockstep_checker.sv
// Dual-lane lockstep ALU: two-stage pipeline, per-op result compare,
// and sticky/counted/first-fault error accounting with fault injection.
module alu_lockstep_checker
    import alu_lockstep_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [1:0]       sel0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       sel1,
    input  logic             inject,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out0,
    output logic [WIDTH-1:0] alu_out1,
    output logic             carry0,
    output logic             carry1,
    output logic [WIDTH-1:0] diff,
    output logic             carry_diff,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH:0]   first_diff
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a0, s1_b0, s1_a1, s1_b1;
    op_t              s1_sel0, s1_sel1;

    logic [WIDTH-1:0] lane_out0, lane_out1, lane_diff;
    logic             lane_c0, lane_c1, lane_cdiff;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s1_valid <= 1'b0;
            s1_a0    <= '0;
            s1_b0    <= '0;
            s1_sel0  <= OP_ADD;
            s1_a1    <= '0;
            s1_b1    <= '0;
            s1_sel1  <= OP_ADD;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a0   <= a0;
                s1_b0   <= b0;
                s1_sel0 <= sel0;
                // Flipping lane-1 a[0] forces a divergence to prove the checker is live.
                s1_a1   <= a1 ^ {{(WIDTH-1){1'b0}}, inject};
                s1_b1   <= b1;
                s1_sel1 <= sel1;
            end
        end
    end

    alu_lane #(.WIDTH(WIDTH)) u_lane0 (
        .a      (s1_a0),
        .b      (s1_b0),
        .sel    (s1_sel0),
        .result (lane_out0),
        .carry  (lane_c0)
    );

    alu_lane #(.WIDTH(WIDTH)) u_lane1 (
        .a      (s1_a1),
        .b      (s1_b1),
        .sel    (s1_sel1),
        .result (lane_out1),
        .carry  (lane_c1)
    );

    assign lane_diff  = lane_out0 ^ lane_out1;
    assign lane_cdiff = lane_c0 ^ lane_c1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_valid  <= 1'b0;
            alu_out0   <= '0;
            alu_out1   <= '0;
            carry0     <= 1'b0;
            carry1     <= 1'b0;
            diff       <= '0;
            carry_diff <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            mismatch  <= s1_valid & ((|lane_diff) | lane_cdiff);
            if (s1_valid) begin
                alu_out0   <= lane_out0;
                alu_out1   <= lane_out1;
                carry0     <= lane_c0;
                carry1     <= lane_c1;
                diff       <= lane_diff;
                carry_diff <= lane_cdiff;
            end
        end
    end

    // Clear has priority: a mismatch on the clear cycle is neither counted nor captured.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            first_diff <= '0;
        end else if (clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            first_diff <= '0;
        end else if (mismatch) begin
            err_sticky <= 1'b1;
            if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
            if (!err_sticky) first_diff <= {carry_diff, diff};
        end
    end

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// Scoreboard bench for alu_lockstep_checker (WIDTH=4, CNT_W=2) with directed vectors.
module tb_alu_lockstep_checker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]       sel0 = '0, sel1 = '0;
    logic             inject = 1'b0;
    logic             clr = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] alu_out0, alu_out1, diff;
    logic             carry0, carry1, carry_diff, mismatch, err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic [WIDTH:0]   first_diff;

    typedef struct packed {
        logic [WIDTH-1:0] o0;
        logic             c0;
        logic [WIDTH-1:0] o1;
        logic             c1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   run = 0;
    int   last_run = 0;

    always #5 clk = ~clk;

    alu_lockstep_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .in_valid   (in_valid),
        .a0         (a0),
        .b0         (b0),
        .sel0       (sel0),
        .a1         (a1),
        .b1         (b1),
        .sel1       (sel1),
        .inject     (inject),
        .clr        (clr),
        .out_valid  (out_valid),
        .alu_out0   (alu_out0),
        .alu_out1   (alu_out1),
        .carry0     (carry0),
        .carry1     (carry1),
        .diff       (diff),
        .carry_diff (carry_diff),
        .mismatch   (mismatch),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .first_diff (first_diff)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [3:0] ia0, input logic [3:0] ib0, input logic [1:0] is0,
                         input logic [3:0] ia1, input logic [3:0] ib1, input logic [1:0] is1,
                         input logic inj, input logic push,
                         input logic [3:0] e_o0, input logic e_c0,
                         input logic [3:0] e_o1, input logic e_c1);
        a0 = ia0; b0 = ib0; sel0 = is0;
        a1 = ia1; b1 = ib1; sel1 = is1;
        inject = inj;
        in_valid = 1'b1;
        if (push) sb.push_back('{o0: e_o0, c0: e_c0, o1: e_o1, c1: e_c1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        inject = 1'b0;
    endtask

    task automatic check_err(input string tag, input logic exp_sticky,
                             input logic [CNT_W-1:0] exp_cnt, input logic [WIDTH:0] exp_fd);
        check({tag, " err_sticky"}, 32'(err_sticky), 32'(exp_sticky));
        check({tag, " err_cnt"},    32'(err_cnt),    32'(exp_cnt));
        check({tag, " first_diff"}, 32'(first_diff), 32'(exp_fd));
    endtask

    // Monitor: pops one expectation per out_valid cycle and tracks valid run length.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                run++;
                if (sb.size() == 0) begin
                    check("unexpected out_valid", 32'(out_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("alu_out0",   32'(alu_out0),   32'(e.o0));
                    check("carry0",     32'(carry0),     32'(e.c0));
                    check("alu_out1",   32'(alu_out1),   32'(e.o1));
                    check("carry1",     32'(carry1),     32'(e.c1));
                    check("diff",       32'(diff),       32'(e.o0 ^ e.o1));
                    check("carry_diff", 32'(carry_diff), 32'(e.c0 ^ e.c1));
                    check("mismatch",   32'(mismatch),   32'((|(e.o0 ^ e.o1)) | (e.c0 ^ e.c1)));
                end
            end else begin
                if (run > 0) last_run = run;
                run = 0;
                check("mismatch without out_valid", 32'(mismatch), 32'h0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset alu_out0",  32'(alu_out0),  32'h0);
        check("reset alu_out1",  32'(alu_out1),  32'h0);
        check("reset mismatch",  32'(mismatch),  32'h0);
        check_err("reset", 1'b0, 2'd0, 5'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD, SUB, AND, XOR back-to-back on both lanes
        issue(4'h9, 4'h8, 2'b00, 4'h9, 4'h8, 2'b00, 1'b0, 1'b1, 4'h1, 1'b1, 4'h1, 1'b1);
        issue(4'h3, 4'h5, 2'b01, 4'h3, 4'h5, 2'b01, 1'b0, 1'b1, 4'hE, 1'b1, 4'hE, 1'b1);
        issue(4'hC, 4'hA, 2'b10, 4'hC, 4'hA, 2'b10, 1'b0, 1'b1, 4'h8, 1'b0, 4'h8, 1'b0);
        issue(4'hC, 4'hA, 2'b11, 4'hC, 4'hA, 2'b11, 1'b0, 1'b1, 4'h6, 1'b0, 4'h6, 1'b0);
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("back-to-back out_valid run", 32'(last_run), 32'd4);
        check_err("no-fault", 1'b0, 2'd0, 5'h00);

        // Injected ADD 2+2: lane 1 sees 3+2
        issue(4'h2, 4'h2, 2'b00, 4'h2, 4'h2, 2'b00, 1'b1, 1'b1, 4'h4, 1'b0, 4'h5, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_err("first inject", 1'b1, 2'd1, 5'h01);

        // Later XOR mismatch keeps the first capture
        issue(4'hC, 4'hA, 2'b11, 4'hC, 4'hA, 2'b11, 1'b1, 1'b1, 4'h6, 1'b0, 4'h7, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_err("second inject", 1'b1, 2'd2, 5'h01);

        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_err("after clr", 1'b0, 2'd0, 5'h00);

        // Five injected ops saturate the 2-bit counter
        for (int i = 0; i < 5; i++)
            issue(4'h2, 4'h2, 2'b00, 4'h2, 4'h2, 2'b00, 1'b1, 1'b1, 4'h4, 1'b0, 4'h5, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_err("saturated", 1'b1, 2'd3, 5'h01);

        // Clear coincident with a mismatch wins
        issue(4'h2, 4'h2, 2'b00, 4'h2, 4'h2, 2'b00, 1'b1, 1'b1, 4'h4, 1'b0, 4'h5, 1'b0);
        idle();
        @(posedge clk);
        #1;
        check("mismatch on clr cycle", 32'(mismatch), 32'h1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_err("clr vs mismatch", 1'b0, 2'd0, 5'h00);
        repeat (2) @(posedge clk);
        #1;
        check_err("clr vs mismatch later", 1'b0, 2'd0, 5'h00);

        // Mixed ops: ADD F+1 vs XOR F^1
        issue(4'hF, 4'h1, 2'b00, 4'hF, 4'h1, 2'b11, 1'b0, 1'b1, 4'h0, 1'b1, 4'hE, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_err("mixed ops", 1'b1, 2'd1, 5'h1E);

        // Reset with two ops in flight: neither may appear
        issue(4'h1, 4'h1, 2'b00, 4'h1, 4'h1, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        a0 = 4'h3; a1 = 4'h3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        check("mid-reset out_valid", 32'(out_valid), 32'h0);
        check("mid-reset alu_out0",  32'(alu_out0),  32'h0);
        check("mid-reset diff",      32'(diff),      32'h0);
        check_err("mid-reset", 1'b0, 2'd0, 5'h00);
        repeat (3) @(posedge clk);
        #1;
        check("post-reset out_valid", 32'(out_valid), 32'h0);

        issue(4'h9, 4'h8, 2'b00, 4'h9, 4'h8, 2'b00, 1'b0, 1'b1, 4'h1, 1'b1, 4'h1, 1'b1);
        idle();
        @(posedge clk);
        #1;
        check("post-reset op out_valid", 32'(out_valid), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check_err("post-reset op", 1'b0, 2'd0, 5'h00);

        // Every expected response must have been consumed within a bounded drain
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_lockstep_checker.md
# alu_lockstep_checker

Parametrised dual-lane lockstep ALU with registered pipeline and error accounting; next generation of the team's paired-ALU comparator in the user project wrapper. Two identical ALU lanes execute independent operations each cycle. The block registers both results, flags any result or carry divergence per operation, and keeps a sticky error flag, a saturating mismatch counter and a first-fault capture. It adds a fault-injection mode to prove the checker is live, and sits between the GPIO/LA input decode and the `io_out` drive in the wrapper.

## Interface
- `WIDTH`, 4: operand/result width per lane (≥2).
- `CNT_W`, 8: mismatch counter width (≥2).
- `wb_clk_i` in 1: single clock, rising edge.
- `wb_rst_ni` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: operands on lane inputs valid this cycle.
- `a0`, `b0` in WIDTH: lane-0 operands.
- `sel0` in 2: lane-0 op select.
- `a1`, `b1` in WIDTH: lane-1 operands.
- `sel1` in 2: lane-1 op select.
- `inject` in 1: fault injection, sampled with `in_valid`.
- `clr` in 1: synchronous clear of error state.
- `out_valid` out 1: results/compare outputs valid.
- `alu_out0`, `alu_out1` out WIDTH: lane results.
- `carry0`, `carry1` out 1: lane carry/borrow flags.
- `diff` out WIDTH: `alu_out0 ^ alu_out1`.
- `carry_diff` out 1: `carry0 ^ carry1`.
- `mismatch` out 1: `out_valid & (|diff | carry_diff)`.
- `err_sticky` out 1: set on any mismatch, held until `clr`/reset.
- `err_cnt` out CNT_W: saturating mismatch count.
- `first_diff` out WIDTH+1: `{carry_diff, diff}` of first mismatch since reset/clr.

## Operation
- Op encoding: 00 ADD (carry = bit WIDTH of a+b); 01 SUB (a−b mod 2^WIDTH, carry = borrow, i.e. a<b unsigned); 10 AND (carry 0); 11 XOR (carry 0).
- Stage 1 (S1): on `in_valid`, register a/b/sel of both lanes. If `inject`=1, lane-1 `a` LSB is inverted when registered. S1 valid bit = `in_valid`.
- Stage 2 (S2): compute both lanes from S1, register results, carries, `diff`, `carry_diff`, `out_valid`, `mismatch`. Stages with valid=0 hold their data; `out_valid`=0 forces `mismatch`=0.
- Error state (S3): on a cycle where `mismatch`=1, `err_sticky` set, `err_cnt` increments (holds at 2^CNT_W−1), and `first_diff` loads if `err_sticky` was 0.
- `clr`=1: `err_sticky`, `err_cnt`, `first_diff` → 0 on next edge. Clear wins over a simultaneous mismatch; that mismatch is not counted or captured. Pipeline stages are unaffected by `clr`.
- No backpressure. The block accepts one op per cycle, back-to-back.

## Timing
- Reset: every output and internal register is 0, including the valid bits.
- Latency: `in_valid` sampled at edge E → `out_valid`, results, `diff`, `mismatch` at E+1 (visible after the second edge from the input cycle, i.e. T+2 cycles).
- `err_sticky`/`err_cnt`/`first_diff` reflect that mismatch one edge later (T+3).
- Throughput: 1 op/cycle. Gaps in `in_valid` propagate as gaps in `out_valid`.
- Reset asserted mid-pipeline: in-flight ops are discarded and no `out_valid` is produced for them. Ops issued after deassertion behave normally.
- Reset deassertion must be synchronised externally to `wb_clk_i`.

## Structure
- Package `alu_lockstep_pkg`: op-select localparams (`OP_ADD`, `OP_SUB`, `OP_AND`, `OP_XOR`) and 2-bit op type.
- Sub-module `alu_lane`: combinational WIDTH-parametrised ALU (a, b, sel → out, carry), instantiated twice. The top level owns all registers, inject logic, compare and error accounting.

## Test plan
- ADD both lanes a=9, b=8, WIDTH=4 → T+2: `alu_out0`=`alu_out1`=1, carries=1, `mismatch`=0, `err_cnt`=0.
- SUB a=3, b=5 both lanes → out=0xE, carry=1. AND 0xC/0xA → 0x8, carry 0. XOR 0xC/0xA → 0x6, carry 0. Issue back-to-back; `out_valid` high 4 consecutive cycles.
- Identical ADD 2+2 with `inject`=1 → lane 1 computes 3+2: `diff`=0x1, `mismatch`=1 at T+2. At T+3: `err_sticky`=1, `err_cnt`=1, `first_diff`=0x01. A later XOR mismatch leaves `first_diff` unchanged.
- CNT_W=2, five consecutive injected ops → `err_cnt` reaches 3 and holds. `clr` asserted on the cycle of a further `mismatch` → all error state 0, count stays 0.
- Lane 0 ADD 0xF+1, lane 1 XOR 0xF^1 → outs 0x0/0xE, carries 1/0, `first_diff`=0x1E.
- `wb_rst_ni` low for one cycle while two ops are in flight → no `out_valid` for them, all outputs 0. A new op after release completes normally at T+2.
